// File: rtl/rvvi_flow_ctrl_pkg.sv
// Shared types for the RVVI trace-link transmit flow controller.
// Holds the core configuration subset, the controller FSM encoding and a small arithmetic helper.
package rvvi_flow_ctrl_pkg;

    // Only XLEN of the full core configuration matters to the flow controller.
    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd32};

    // Exported so packetizer-side monitors can decode the controller state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } rvvi_flow_state_t;

    localparam int GAP_CNT_W = 32;

    // Unsigned add that clips at max_val instead of wrapping.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            sat_add = max_val;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/rvvi_flow_ctrl_if.sv
// Bundle of host-ack, core and packetizer signals seen by the flow controller.
// The master side is the surrounding system; the slave side is the controller.
interface rvvi_flow_ctrl_if #(
    parameter int XLEN = 32,
    parameter int FCW  = 16
);

    logic            HostValid;
    logic [XLEN-1:0] HostMinstr;
    logic [31:0]     HostDelay;
    logic [FCW-1:0]  HostFrameCount;
    logic [XLEN-1:0] LocalMinstr;
    logic            TxReq;
    logic            TxDone;
    logic            TxGrant;
    logic            Stall;
    logic [XLEN-1:0] AckedMinstr;
    logic [FCW-1:0]  DropCount;
    logic            HostTimeout;

    modport master (
        output HostValid,
        output HostMinstr,
        output HostDelay,
        output HostFrameCount,
        output LocalMinstr,
        output TxReq,
        output TxDone,
        input  TxGrant,
        input  Stall,
        input  AckedMinstr,
        input  DropCount,
        input  HostTimeout
    );

    modport slave (
        input  HostValid,
        input  HostMinstr,
        input  HostDelay,
        input  HostFrameCount,
        input  LocalMinstr,
        input  TxReq,
        input  TxDone,
        output TxGrant,
        output Stall,
        output AckedMinstr,
        output DropCount,
        output HostTimeout
    );

endinterface

// File: rtl/rvvi_flow_ctrl_gap.sv
// Loadable 32-bit down-counter timing the inter-packet gap.
// Flags are registered from the next count so they line up with the count itself.
module rvvi_gap_timer
    import rvvi_flow_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_load,
    input  logic [GAP_CNT_W-1:0] i_load_val,
    input  logic                 i_en,
    output logic                 o_zero,
    output logic                 o_one
);

    logic [GAP_CNT_W-1:0] r_count;
    logic [GAP_CNT_W-1:0] w_count_next;
    logic                 r_zero;
    logic                 r_one;

    // Next count: load wins over decrement, and the counter parks at zero.
    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_val;
        end else if (i_en && (r_count != 32'd0)) begin
            w_count_next = r_count - 32'd1;
        end else begin
            w_count_next = r_count;
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 32'd0;
            r_zero  <= 1'b1;
            r_one   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_zero  <= (w_count_next == 32'd0);
            r_one   <= (w_count_next == 32'd1);
        end
    end

    assign o_zero = r_zero;
    assign o_one  = r_one;

endmodule

// File: rtl/rvvi_flow_ctrl.sv
// Transmit-side flow controller for the RVVI Ethernet trace link: grants one frame
// at a time, enforces the host-requested gap, and stalls the core on a full ack window.
module rvvi_flow_ctrl
    import rvvi_flow_ctrl_pkg::*;
#(
    parameter cvw_t        P                 = CVW_DEFAULT,
    parameter int          FRAME_COUNT_WIDTH = 16,
    parameter int          WINDOW            = 64,
    parameter logic [31:0] DEFAULT_DELAY     = 32'd0,
    parameter int          TIMEOUT_CYCLES    = 2**20
) (
    input  logic           clk,
    input  logic           resetn,
    rvvi_flow_ctrl_if.slave bus
);

    localparam int XLEN = int'(P.XLEN);
    localparam int FCW  = FRAME_COUNT_WIDTH;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [XLEN-1:0] WINDOW_X   = XLEN'(WINDOW);
    localparam logic [TW-1:0]   TOUT_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [31:0]     DROP_MAX32 = 32'({FCW{1'b1}});

    rvvi_flow_state_t r_state;
    rvvi_flow_state_t w_next_state;

    logic            r_tx_grant;
    logic            r_stall;
    logic [XLEN-1:0] r_acked;
    logic [FCW-1:0]  r_drop;
    logic            r_timeout;
    logic [31:0]     r_delay;
    logic [FCW-1:0]  r_exp_frame;
    logic [TW-1:0]   r_tout_cnt;

    logic [XLEN-1:0] w_outstanding;
    logic [FCW-1:0]  w_frame_diff;
    logic            w_gap_load;
    logic            w_gap_en;
    logic            w_gap_zero;
    logic            w_gap_one;

    assign w_outstanding = bus.LocalMinstr - r_acked;
    assign w_frame_diff  = bus.HostFrameCount - r_exp_frame;
    assign w_gap_en      = (r_state == GAP);

    // The gap load samples r_delay before any same-cycle host update lands.
    rvvi_gap_timer u_gap_timer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_gap_load),
        .i_load_val (r_delay),
        .i_en       (w_gap_en),
        .o_zero     (w_gap_zero),
        .o_one      (w_gap_one)
    );

    // Next-state and gap-load decode for the IDLE/SEND/GAP sequencer.
    always_comb begin
        w_next_state = r_state;
        w_gap_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.TxReq && !r_stall) begin
                    w_next_state = SEND;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SEND: begin
                if (!bus.TxDone) begin
                    w_next_state = SEND;
                end else if (r_delay == 32'd0) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GAP;
                    w_gap_load   = 1'b1;
                end
            end
            GAP: begin
                // Zero is a safety exit; normal gaps leave on the count of one.
                if (w_gap_one || w_gap_zero) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GAP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register plus the registered grant derived from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_tx_grant <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx_grant <= (w_next_state == SEND);
        end
    end

    // Window stall, host-ack bookkeeping, drop accounting and host-silence timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall     <= 1'b0;
            r_acked     <= '0;
            r_drop      <= '0;
            r_timeout   <= 1'b0;
            r_delay     <= DEFAULT_DELAY;
            r_exp_frame <= '0;
            r_tout_cnt  <= '0;
        end else begin
            r_stall <= (w_outstanding >= WINDOW_X);
            if (bus.HostValid) begin
                if (bus.HostMinstr > r_acked) begin
                    r_acked <= bus.HostMinstr;
                end
                r_delay <= bus.HostDelay;
                if (w_frame_diff != '0) begin
                    r_drop <= FCW'(sat_add(32'(r_drop), 32'(w_frame_diff), DROP_MAX32));
                end
                r_exp_frame <= bus.HostFrameCount + FCW'(1);
                r_tout_cnt  <= '0;
                r_timeout   <= 1'b0;
            end else begin
                if ((w_outstanding != '0) && (r_tout_cnt != TOUT_MAX)) begin
                    r_tout_cnt <= r_tout_cnt + TW'(1);
                end
                r_timeout <= (r_tout_cnt == TOUT_MAX);
            end
        end
    end

    assign bus.TxGrant     = r_tx_grant;
    assign bus.Stall       = r_stall;
    assign bus.AckedMinstr = r_acked;
    assign bus.DropCount   = r_drop;
    assign bus.HostTimeout = r_timeout;

endmodule

// File: tb/tb_rvvi_flow_ctrl.sv
// Directed bench for rvvi_flow_ctrl: reset, gap timing, window stall, drop counting and timeout.
module tb_rvvi_flow_ctrl;
    import rvvi_flow_ctrl_pkg::*;

    localparam cvw_t TB_P = '{XLEN: 32'd32};

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    int   low;
    int   n;

    always #5 clk = ~clk;

    rvvi_flow_ctrl_if #(.XLEN(32), .FCW(16)) bus ();

    rvvi_flow_ctrl #(
        .P                 (TB_P),
        .FRAME_COUNT_WIDTH (16),
        .WINDOW            (64),
        .DEFAULT_DELAY     (32'd2),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_ack(input logic [31:0] m, input logic [31:0] d, input logic [15:0] f);
        bus.HostValid      = 1'b1;
        bus.HostMinstr     = m;
        bus.HostDelay      = d;
        bus.HostFrameCount = f;
        tick();
        bus.HostValid = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int k;
        k = 0;
        while (bus.TxGrant !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check(tag, 64'(bus.TxGrant), 64'd1);
    endtask

    // Pulse TxDone (and any HostValid already set up), then count grant-low cycles.
    task automatic done_gap(output int lo);
        bus.TxDone = 1'b1;
        tick();
        bus.TxDone    = 1'b0;
        bus.HostValid = 1'b0;
        lo = 0;
        while (bus.TxGrant !== 1'b1 && lo < 100) begin
            lo++;
            tick();
        end
    endtask

    initial begin
        resetn             = 1'b0;
        bus.HostValid      = 1'b0;
        bus.HostMinstr     = 32'd0;
        bus.HostDelay      = 32'd0;
        bus.HostFrameCount = 16'd0;
        bus.LocalMinstr    = 32'd0;
        bus.TxReq          = 1'b0;
        bus.TxDone         = 1'b0;
        repeat (3) tick();
        check("rst_grant",   64'(bus.TxGrant),     64'd0);
        check("rst_stall",   64'(bus.Stall),       64'd0);
        check("rst_acked",   64'(bus.AckedMinstr), 64'd0);
        check("rst_drop",    64'(bus.DropCount),   64'd0);
        check("rst_timeout", 64'(bus.HostTimeout), 64'd0);
        resetn = 1'b1;
        tick();

        // Frame 3 first: three frames missed, and delay becomes 7.
        host_ack(32'd0, 32'd7, 16'd3);
        check("drop_pre_reset", 64'(bus.DropCount), 64'd3);
        bus.TxReq = 1'b1;
        wait_grant("grant_pre_reset");
        resetn = 1'b0;
        #1;
        check("async_grant_drop", 64'(bus.TxGrant), 64'd0);
        tick();
        resetn = 1'b1;
        check("drop_after_reset", 64'(bus.DropCount), 64'd0);
        wait_grant("grant_after_reset");
        done_gap(low);
        check("default_delay_gap", 64'(low), 64'd3);

        // Delay 5: grant low for the 5 GAP cycles plus the IDLE cycle.
        host_ack(32'd0, 32'd5, 16'd0);
        done_gap(low);
        check("gap5_low", 64'(low), 64'd6);
        bus.TxReq  = 1'b0;
        bus.TxDone = 1'b1;
        tick();
        bus.TxDone = 1'b0;
        repeat (8) tick();
        check("idle_no_req", 64'(bus.TxGrant), 64'd0);

        // Window boundary and one-cycle stall latency.
        bus.LocalMinstr = 32'd20;
        host_ack(32'd20, 32'd0, 16'd1);
        check("acked_20", 64'(bus.AckedMinstr), 64'd20);
        bus.LocalMinstr = 32'd83;
        tick();
        check("stall_out63", 64'(bus.Stall), 64'd0);
        bus.LocalMinstr = 32'd84;
        check("stall_latency_rise", 64'(bus.Stall), 64'd0);
        tick();
        check("stall_out64", 64'(bus.Stall), 64'd1);
        bus.LocalMinstr = 32'd100;
        host_ack(32'd36, 32'd0, 16'd2);
        tick();
        check("stall_100_36", 64'(bus.Stall), 64'd1);
        bus.TxReq = 1'b1;
        repeat (3) tick();
        check("no_grant_stalled", 64'(bus.TxGrant), 64'd0);
        host_ack(32'd40, 32'd0, 16'd3);
        check("stall_latency_fall", 64'(bus.Stall), 64'd1);
        tick();
        check("stall_100_40", 64'(bus.Stall), 64'd0);
        wait_grant("grant_unstalled");
        done_gap(low);
        check("gap0_low", 64'(low), 64'd1);

        // Stale ack keeps AckedMinstr but still updates the delay.
        host_ack(32'd50, 32'd1, 16'd4);
        check("acked_50", 64'(bus.AckedMinstr), 64'd50);
        host_ack(32'd10, 32'd3, 16'd5);
        check("stale_ack", 64'(bus.AckedMinstr), 64'd50);
        bus.HostValid      = 1'b1;
        bus.HostMinstr     = 32'd50;
        bus.HostDelay      = 32'd9;
        bus.HostFrameCount = 16'd6;
        done_gap(low);
        check("simul_old_gap3", 64'(low), 64'd4);
        done_gap(low);
        check("next_gap9", 64'(low), 64'd10);
        check("drop_in_order", 64'(bus.DropCount), 64'd0);
        bus.TxReq  = 1'b0;
        bus.TxDone = 1'b1;
        tick();
        bus.TxDone = 1'b0;
        repeat (12) tick();

        // Drop counting with wrap and saturation, from a fresh reset.
        resetn          = 1'b0;
        bus.LocalMinstr = 32'd0;
        tick();
        resetn = 1'b1;
        tick();
        host_ack(32'd0, 32'd0, 16'd0);
        host_ack(32'd0, 32'd0, 16'd1);
        host_ack(32'd0, 32'd0, 16'd4);
        check("drop_0_1_4", 64'(bus.DropCount), 64'd2);
        host_ack(32'd0, 32'd0, 16'hFFFE);
        check("drop_jump", 64'(bus.DropCount), 64'hFFFB);
        host_ack(32'd0, 32'd0, 16'hFFFF);
        host_ack(32'd0, 32'd0, 16'h0000);
        check("drop_wrap_ok", 64'(bus.DropCount), 64'hFFFB);
        host_ack(32'd0, 32'd0, 16'd10);
        check("drop_saturate", 64'(bus.DropCount), 64'hFFFF);
        host_ack(32'd0, 32'd0, 16'd20);
        check("drop_no_wrap", 64'(bus.DropCount), 64'hFFFF);

        // Host silence with 5 outstanding instructions.
        bus.LocalMinstr = 32'd5;
        host_ack(32'd0, 32'd0, 16'd21);
        check("timeout_cleared", 64'(bus.HostTimeout), 64'd0);
        n = 0;
        while (bus.HostTimeout !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd17);
        repeat (3) tick();
        check("timeout_held", 64'(bus.HostTimeout), 64'd1);
        host_ack(32'd0, 32'd0, 16'd22);
        check("timeout_ack_clear", 64'(bus.HostTimeout), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvvi_flow_ctrl.md
Name: rvvi_flow_ctrl

Overview:
- Transmit-side flow controller for the RVVI Ethernet trace link.
- Consumes per-frame host acknowledgements from the host-return frame parser: valid pulse, acked minstret, inter-packet delay, frame count.
- Grants the RVVI packetizer permission to send one frame at a time and enforces the host-requested inter-packet gap.
- Stalls the core when too many retired instructions are unacknowledged. Also tracks dropped host frames and host silence.

Parameters:
- P, cvw_t, core configuration; only P.XLEN is used.
- FRAME_COUNT_WIDTH, 16, width of the host frame counter.
- WINDOW, 64, maximum unacknowledged instructions before Stall asserts.
- DEFAULT_DELAY, 32'd0, inter-packet delay used until the first host frame arrives.
- TIMEOUT_CYCLES, 2**20, cycles of host silence with outstanding instructions before HostTimeout asserts.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- HostValid  in  1  one-cycle pulse: a host ack frame was parsed and matched
- HostMinstr  in  P.XLEN  minstret acknowledged by the host
- HostDelay  in  32  requested inter-packet gap, in cycles
- HostFrameCount  in  FRAME_COUNT_WIDTH  host frame sequence number
- LocalMinstr  in  P.XLEN  core's current retired-instruction count
- TxReq  in  1  packetizer has a frame ready
- TxDone  in  1  one-cycle pulse: frame fully sent
- TxGrant  out  1  packetizer may send / is sending
- Stall  out  1  core must stop retiring
- AckedMinstr  out  P.XLEN  highest minstret acknowledged so far
- DropCount  out  FRAME_COUNT_WIDTH  saturating count of missed host frames
- HostTimeout  out  1  host silent too long

Behaviour:
- Reset (resetn=0, async):
  - FSM goes to IDLE; TxGrant drops immediately.
  - Outputs clear: Stall=0, AckedMinstr=0, DropCount=0, HostTimeout=0.
  - Internal state clears: DelayReg=DEFAULT_DELAY, ExpFrame=0, GapCnt=0, TimeoutCnt=0.
  - Reset mid-frame abandons the grant; the packetizer is reset alongside.
- Host ack update (clock edge with HostValid=1):
  - AckedMinstr <= HostMinstr only if HostMinstr > AckedMinstr (unsigned). Stale or duplicate acks are ignored.
  - DelayReg <= HostDelay.
  - If HostFrameCount != ExpFrame: DropCount += (HostFrameCount - ExpFrame) mod 2^FRAME_COUNT_WIDTH, saturating at all-ones.
  - ExpFrame <= HostFrameCount+1, wrapping.
  - TimeoutCnt <= 0; HostTimeout <= 0.
- Window / Stall:
  - Outstanding = LocalMinstr - AckedMinstr, modulo 2^XLEN.
  - Stall is registered: Stall <= (Outstanding >= WINDOW). One-cycle latency from any input change.
- Timeout:
  - When Outstanding != 0 and HostValid=0: TimeoutCnt increments, saturating at TIMEOUT_CYCLES.
  - HostTimeout <= (TimeoutCnt == TIMEOUT_CYCLES). Status only; it does not gate TxGrant.
  - When Outstanding == 0: TimeoutCnt holds.
- FSM (Moore), states IDLE, SEND, GAP:
  - IDLE: TxReq & ~Stall -> SEND. TxDone in IDLE is ignored.
  - SEND: TxGrant=1. Stays in SEND until TxDone, even if TxReq drops or Stall rises mid-frame.
  - On TxDone: if DelayReg==0 -> IDLE; else GapCnt <= DelayReg and -> GAP.
  - GAP: TxGrant=0; GapCnt decrements each cycle; GapCnt==1 -> IDLE. This gives exactly DelayReg cycles in GAP.
  - A DelayReg update during GAP does not change the current gap.
- TxGrant timing:
  - TxGrant is registered: it rises the cycle after IDLE sees TxReq & ~Stall.
  - Minimum frame-to-frame spacing is DelayReg+1 cycles after TxDone.
- Simultaneous HostValid and TxDone: GapCnt loads the pre-update DelayReg; the new value applies to the next gap.
- Arithmetic: all compares unsigned; GapCnt is 32 bits; DropCount never wraps.

Decomposition:
- Shared package cvw: add typedef enum rvvi_flow_state_t {IDLE, SEND, GAP} for reuse by the packetizer testbench monitors.
- One sub-module, rvvi_gap_timer: 32-bit loadable down-counter with load, enable and zero/one flags. The FSM and window logic stay in the top module.

Test Plan:
- Reset mid-SEND (TxGrant=1, pulse resetn low) -> TxGrant=0 asynchronously; after release, DelayReg=DEFAULT_DELAY and DropCount=0.
- HostDelay=5 acked, TxReq held, TxDone pulsed at t -> TxGrant low for exactly 5 GAP cycles, re-asserts at t+7.
- LocalMinstr=100, HostMinstr=36 acked (Outstanding=64) -> Stall=1 next cycle; HostMinstr=40 -> Stall=0 next cycle; TxGrant not issued while Stall=1.
- HostFrameCount sequence 0,1,4 -> DropCount=2; then 0xFFFF,0x0000 -> no added drops. Sequence forcing a count >0xFFFF -> DropCount saturates at 0xFFFF.
- Stale ack HostMinstr=10 after AckedMinstr=50 -> AckedMinstr stays 50, but DelayReg updates. Simultaneous HostValid (HostDelay=9) and TxDone with old DelayReg=3 -> gap is 3 cycles, next gap is 9.
- Outstanding>0, no HostValid for TIMEOUT_CYCLES (set to 16 in sim) -> HostTimeout=1 after 16+1 cycles; one HostValid -> HostTimeout=0 next cycle.
